// File: rtl/jt12_dac_ctrl_pkg.sv
// Shared types for the jt12_dac sample scheduler.
// Gain ramp state encoding and full-scale gain helper.
package jt12_dac_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    function automatic int unsigned full_gain(input int unsigned gw);
        return 32'd1 << gw;
    endfunction

endpackage

// File: rtl/jt12_dac_ctrl_rr.sv
// Two-input round-robin arbiter; pointer 0 favours input a.
// Grants are combinational and only asserted while en is high.
module jt12_dac_ctrl_rr (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid_a,
    input  logic valid_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr;

    // grant the lone requester, or the favoured one on contention
    always_comb begin
        gnt_a = en & valid_a & (~valid_b | ~ptr);
        gnt_b = en & valid_b & (~valid_a | ptr);
    end

    // flip priority only after a contended grant
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (en & valid_a & valid_b)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/jt12_dac_ctrl.sv
// Tick-paced FM/PCM sample scheduler with anti-pop gain ramp.
// Optional JT12_DAC_CTRL_STATS_EN adds a saturating underrun_cnt.
module jt12_dac_ctrl
    import jt12_dac_ctrl_pkg::*;
#(
    parameter int W   = 12,
    parameter int DIV = 256,
    parameter int GW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mute,
    input  logic signed [W-1:0] fm_snd,
    input  logic                fm_valid,
    output logic                fm_ready,
    input  logic signed [W-1:0] pcm_snd,
    input  logic                pcm_valid,
    output logic                pcm_ready,
    output logic signed [W-1:0] dac_din,
    output logic                tick,
    output logic [1:0]          state
`ifdef JT12_DAC_CTRL_STATS_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = W + GW + 2;
    localparam logic [GW:0] GFULL = (GW+1)'(full_gain(GW));
    localparam logic [GW:0] GONE  = (GW+1)'(1);

    logic [CW-1:0]       count;
    state_t              st, st_n;
    logic [GW:0]         gain, gain_n;
    logic signed [W-1:0] last, sample, dac_n;
    logic signed [PW-1:0] s_ext, g_ext;
    logic                elig, gnt_fm, gnt_pcm;

    assign tick      = (count == CW'(DIV - 1));
    assign elig      = tick & ((st != IDLE) | ~mute);
    assign fm_ready  = gnt_fm;
    assign pcm_ready = gnt_pcm;
    assign state     = st;

    // free-running sample divider
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    jt12_dac_ctrl_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .en      (elig),
        .valid_a (fm_valid),
        .valid_b (pcm_valid),
        .gnt_a   (gnt_fm),
        .gnt_b   (gnt_pcm)
    );

    // pick the granted sample, otherwise replay the held one
    always_comb begin
        sample = last;
        if (gnt_fm)
            sample = fm_snd;
        else if (gnt_pcm)
            sample = pcm_snd;
    end

    // gain ramp next-state; clamps at both ends of the ramp
    always_comb begin
        st_n   = st;
        gain_n = gain;
        unique case (st)
            IDLE: begin
                if (!mute) begin
                    st_n   = RAMP_UP;
                    gain_n = GONE;
                end else begin
                    gain_n = '0;
                end
            end
            PLAY: begin
                if (mute) begin
                    st_n   = RAMP_DOWN;
                    gain_n = GFULL - GONE;
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (mute) begin
                    gain_n = gain - GONE;
                    st_n   = (gain_n == '0) ? IDLE : RAMP_DOWN;
                end else begin
                    gain_n = gain + GONE;
                    st_n   = (gain_n == GFULL) ? PLAY : RAMP_UP;
                end
            end
        endcase
    end

    // scale by the new gain; arithmetic shift floors negatives
    always_comb begin
        s_ext = PW'(sample);
        g_ext = $signed(PW'(gain_n));
        dac_n = W'((s_ext * g_ext) >>> GW);
    end

    // all scheduler state advances on tick only
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            gain    <= '0;
            last    <= '0;
            dac_din <= '0;
        end else if (tick) begin
            st      <= st_n;
            gain    <= gain_n;
            dac_din <= dac_n;
            if (gnt_fm | gnt_pcm)
                last <= sample;
        end
    end

`ifdef JT12_DAC_CTRL_STATS_EN
    // saturating count of eligible ticks without a transfer
    always_ff @(posedge clk) begin
        if (rst)
            underrun_cnt <= '0;
        else if (elig & ~gnt_fm & ~gnt_pcm & (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_jt12_dac_ctrl.sv
// Scoreboard bench for jt12_dac_ctrl (DIV=4, GW=4, W=12).
// Reference model predicts grants and dac_din per tick.
module tb_jt12_dac_ctrl;

    localparam int W    = 12;
    localparam int DIV  = 4;
    localparam int GW   = 4;
    localparam int FULL = 1 << GW;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                mute = 1'b1;
    logic signed [W-1:0] fm_snd = '0;
    logic                fm_valid = 1'b0;
    logic                fm_ready;
    logic signed [W-1:0] pcm_snd = '0;
    logic                pcm_valid = 1'b0;
    logic                pcm_ready;
    logic signed [W-1:0] dac_din;
    logic                tick;
    logic [1:0]          state;
`ifdef JT12_DAC_CTRL_STATS_EN
    logic [15:0]         underrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    jt12_dac_ctrl #(.W(W), .DIV(DIV), .GW(GW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mute      (mute),
        .fm_snd    (fm_snd),
        .fm_valid  (fm_valid),
        .fm_ready  (fm_ready),
        .pcm_snd   (pcm_snd),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .dac_din   (dac_din),
        .tick      (tick),
        .state     (state)
`ifdef JT12_DAC_CTRL_STATS_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model
    int cnt = 0;
    int m_state = 0, m_gain = 0, m_last = 0, m_ptr = 0, m_uc = 0;
    int q_dac[$];
    int q_st[$];
    int q_uc[$];

    always @(posedge clk) begin
        if (rst)
            cnt <= 0;
        else
            cnt <= (cnt == DIV - 1) ? 0 : cnt + 1;
    end

    always @(negedge clk) begin
        int ef, ep, s, ns, ng, elig, prod;
        if (q_dac.size() > 0) begin
            chk("sb_dac", int'(dac_din), q_dac.pop_front());
            chk("sb_state", int'(state), q_st.pop_front());
`ifdef JT12_DAC_CTRL_STATS_EN
            chk("sb_ucnt", int'(underrun_cnt), q_uc.pop_front());
`else
            void'(q_uc.pop_front());
`endif
        end
        if (rst) begin
            m_state = 0; m_gain = 0; m_last = 0; m_ptr = 0; m_uc = 0;
        end else begin
            chk("tick", int'(tick), (cnt == DIV - 1) ? 1 : 0);
            ef = 0;
            ep = 0;
            if (cnt == DIV - 1) begin
                elig = (m_state != 0 || !mute) ? 1 : 0;
                if (elig != 0) begin
                    if (fm_valid && pcm_valid) begin
                        if (m_ptr == 0) ef = 1; else ep = 1;
                        m_ptr = 1 - m_ptr;
                    end else if (fm_valid) ef = 1;
                    else if (pcm_valid) ep = 1;
                    if (ef == 0 && ep == 0 && m_uc < 65535) m_uc++;
                end
                s = ef != 0 ? int'(fm_snd) : ep != 0 ? int'(pcm_snd) : m_last;
                if (ef != 0 || ep != 0) m_last = s;
                ns = m_state;
                ng = m_gain;
                case (m_state)
                    0: if (!mute) begin ns = 1; ng = 1; end else ng = 0;
                    2: if (mute) begin ns = 3; ng = FULL - 1; end
                    default: begin
                        if (mute) begin
                            ng = m_gain - 1;
                            ns = (ng == 0) ? 0 : 3;
                        end else begin
                            ng = m_gain + 1;
                            ns = (ng == FULL) ? 2 : 1;
                        end
                    end
                endcase
                m_state = ns;
                m_gain  = ng;
                prod = s * ng;
                q_dac.push_back(prod >>> GW);
                q_st.push_back(ns);
                q_uc.push_back(m_uc);
            end
            chk("ready", int'({fm_ready, pcm_ready}), ef * 2 + ep);
        end
    end

    task automatic ticks(input int n);
        repeat (n * DIV) @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_dac", int'(dac_din), 0);
        rst = 1'b0;

        // gain 1 with sample -1 floors to -1
        mute = 1'b0;
        fm_snd = -12'sd1;
        fm_valid = 1'b1;
        ticks(1);
        chk("neg_floor", int'(dac_din), -1);
        chk("ramp_state", int'(state), 1);

        // ramp-up to full scale
        fm_snd = 12'sd1024;
        for (int i = 2; i <= FULL; i++) begin
            ticks(1);
            chk("ramp_dac", int'(dac_din), 64 * i);
        end
        chk("play_state", int'(state), 2);

        fm_snd = -12'sd2047;
        ticks(1);
        chk("full_neg", int'(dac_din), -2047);

        // contention alternates FM, PCM
        fm_snd = 12'sd100;
        pcm_snd = -12'sd200;
        pcm_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            chk("arb_dac", int'(dac_din), (i % 2 == 0) ? 100 : -200);
        end

        // underrun holds the last sample
        fm_valid = 1'b0;
        pcm_snd = -12'sd300;
        ticks(1);
        chk("pcm_only", int'(dac_din), -300);
        pcm_valid = 1'b0;
        ticks(3);
        chk("underrun_dac", int'(dac_din), -300);
`ifdef JT12_DAC_CTRL_STATS_EN
        chk("underrun_cnt", int'(underrun_cnt), 3);
`endif

        // reset mid-play
        fm_snd = 12'sd1024;
        fm_valid = 1'b1;
        ticks(1);
        chk("pre_rst_dac", int'(dac_din), 1024);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst2_state", int'(state), 0);
        chk("rst2_dac", int'(dac_din), 0);
        chk("rst2_ready", int'({fm_ready, pcm_ready}), 0);
        rst = 1'b0;
        ticks(1);
        chk("post_rst_state", int'(state), 1);
        chk("post_rst_dac", int'(dac_din), 64);

        // mute while ramping up at gain 5
        ticks(4);
        chk("gain5_dac", int'(dac_din), 320);
        mute = 1'b1;
        for (int g = 4; g >= 0; g--) begin
            ticks(1);
            chk("ramp_dn_dac", int'(dac_din), 64 * g);
        end
        chk("muted_state", int'(state), 0);
        ticks(2);
        chk("muted_dac", int'(dac_din), 0);
        chk("muted_state2", int'(state), 0);

        ticks(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
